// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared sizes and FSM state type for the 4-way round-robin arbiter
package arb_pkg;
    localparam int N_REQ  = 4;
    localparam int IDX_W  = 2;
    localparam int HOLD_W = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;
endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - rotating 4-to-2 priority encoder; search starts after ptr and ends at ptr
module rr_pick
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] mask,
    input  logic [IDX_W-1:0] ptr,
    output logic             found,
    output logic [IDX_W-1:0] idx
);
    logic [IDX_W-1:0] cand;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            // offset N_REQ wraps to ptr itself, giving it the lowest priority
            cand = ptr + IDX_W'(i);
            if (!found && mask[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end
endmodule

// File: rtl/round_robin_arb4.sv
// rtl/round_robin_arb4.sv - 4-requester round-robin arbiter with bounded hold and back-to-back handover
module round_robin_arb4
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid
);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    state_t            state, state_n;
    logic [IDX_W-1:0]  ptr, ptr_n;
    logic [HOLD_W-1:0] hold_cnt, hold_n;
    logic [N_REQ-1:0]  gnt_n;
    logic [IDX_W-1:0]  idx_n;
    logic              valid_n;

    logic [N_REQ-1:0]  pick_mask;
    logic              pick_found;
    logic [IDX_W-1:0]  pick_idx;
    logic              others_pending;
    logic              release_now;

    // Owner is always excluded on release; when release is due to hold expiry
    // another request is pending, so the search lands elsewhere anyway.
    assign pick_mask      = (state == GRANT) ? (req & ~gnt) : req;
    assign others_pending = |(req & ~gnt);
    assign release_now    = done || !req[gnt_idx]
                            || ((hold_cnt == HOLD_LAST) && others_pending);

    rr_pick u_pick (
        .mask  (pick_mask),
        .ptr   (ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        hold_n  = hold_cnt;
        gnt_n   = gnt;
        idx_n   = gnt_idx;
        valid_n = gnt_valid;
        if ((state == IDLE) || release_now) begin
            if (pick_found) begin
                state_n = GRANT;
                ptr_n   = pick_idx;
                hold_n  = '0;
                idx_n   = pick_idx;
                gnt_n   = N_REQ'(1) << pick_idx;
                valid_n = 1'b1;
            end else begin
                state_n = IDLE;
                hold_n  = '0;
                idx_n   = '0;
                gnt_n   = '0;
                valid_n = 1'b0;
            end
        end else if (hold_cnt != HOLD_LAST) begin
            hold_n = hold_cnt + HOLD_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= IDX_W'(N_REQ - 1);
            hold_cnt  <= '0;
            gnt       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            hold_cnt  <= hold_n;
            gnt       <= gnt_n;
            gnt_idx   <= idx_n;
            gnt_valid <= valid_n;
        end
    end
endmodule

// File: tb/tb_round_robin_arb4.sv
// tb/tb_round_robin_arb4.sv - directed self-checking bench for round_robin_arb4
module tb_round_robin_arb4;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;

    int vectors    = 0;
    int miscompares = 0;

    round_robin_arb4 #(.MAX_HOLD(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] NONE = 7'b0;

    function automatic logic [6:0] g(input int i);
        logic [3:0] oh;
        oh = 4'(1) << i;
        return {1'b1, 2'(i), oh};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [6:0] exp);
        logic [6:0] obs;
        obs = {gnt_valid, gnt_idx, gnt};
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed={v,idx,gnt}=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        rst  = 1'b1;
        req  = 4'b0000;
        done = 1'b0;
        #3;
        check("reset_state", NONE);
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("idle_no_req", NONE);

        // all requesting, done every cycle: 0,1,2,3,0
        req = 4'b1111;
        tick();
        check("rr_first_0", g(0));
        done = 1'b1;
        tick(); check("rr_1", g(1));
        tick(); check("rr_2", g(2));
        tick(); check("rr_3", g(3));
        tick(); check("rr_wrap_0", g(0));
        done = 1'b0;

        // release with nothing pending, then a fresh request
        req = 4'b0000;
        tick(); check("release_to_idle", NONE);
        req = 4'b1000;
        tick(); check("idle_to_3", g(3));

        // lone requester 2 holds 20 cycles, never preempted
        req = 4'b0100;
        for (int k = 0; k < 20; k++) begin
            tick();
            check($sformatf("lone_hold_%0d", k), g(2));
        end

        // owner 2 drops, 3 and 0 pending: search 3,0,1,2 picks 3
        req = 4'b1001;
        tick(); check("drop_pick_3", g(3));

        // two contenders, no done: 8 cycles each, alternating
        req = 4'b0011;
        for (int k = 0; k < 24; k++) begin
            tick();
            check($sformatf("maxhold_%0d", k), (((k / 8) % 2) == 0) ? g(0) : g(1));
        end
        tick(); check("maxhold_to_1", g(1));

        // other req bits changing must not disturb the owner
        req = 4'b1110;
        tick(); check("stable_other_change", g(1));
        req = 4'b0110;
        tick(); check("stable_other_change2", g(1));

        // async reset mid-grant, between clock edges
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_drop", NONE);
        tick();
        rst = 1'b0;
        tick(); check("post_reset_pick_1", g(1));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/round_robin_arb4.md
ROUND_ROBIN_ARB4 -- requirements
Module: round_robin_arb4

Interface
REQ-001 Parameter: MAX_HOLD, 8, max consecutive grant cycles for one requester while another request is pending; legal range 2..255.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: req  input  4  request lines, bit i = requester i; level-sensitive.
REQ-005 Port: done  input  1  current owner releases the resource this cycle.
REQ-006 Port: gnt  output  4  registered one-hot grant; all-zero when no owner.
REQ-007 Port: gnt_idx  output  2  registered binary index of the granted requester.
REQ-008 Port: gnt_valid  output  1  registered; high exactly when gnt is non-zero.

Function
REQ-009 FSM states SHALL be IDLE (no owner) and GRANT (one owner).
REQ-010 Arbitration SHALL be round-robin: search order starts at (ptr+1) mod 4, wraps 3->0, and ends at ptr.
REQ-011 ptr SHALL be updated to the newly granted index on every grant.
REQ-012 IDLE, any req bit high -> GRANT next cycle with gnt/gnt_idx/gnt_valid set to the winner; latency exactly 1 cycle from req sample.
REQ-013 IDLE, req == 0 -> remain IDLE, outputs zero.
REQ-014 GRANT: release condition SHALL be done=1, or req[gnt_idx]=0, or (hold_cnt == MAX_HOLD-1 and any other req bit high).
REQ-015 hold_cnt SHALL be 0 in the first grant cycle, increment each GRANT cycle, saturate at MAX_HOLD-1, and clear on every new grant.
REQ-016 On release with any req bit high (evaluated excluding the releasing index if done=1 or its req is low), the next winner SHALL be granted the following cycle, with no idle gap (back-to-back).
REQ-017 On release with no eligible request -> IDLE next cycle, outputs zero.
REQ-018 Without release, gnt SHALL remain stable; changes on other req bits SHALL NOT affect gnt.
REQ-019 Single requester holding req with no others pending SHALL keep the grant indefinitely (no preemption).
REQ-020 Simultaneous done and new req bits SHALL be resolved in the same cycle per REQ-010 and REQ-016.
REQ-021 gnt SHALL always equal the one-hot decode of gnt_idx when gnt_valid=1; gnt_idx SHALL be 0 when gnt_valid=0.

Reset
REQ-022 On rst assertion, immediately: state IDLE, gnt=4'b0000, gnt_idx=2'b00, gnt_valid=0, hold_cnt=0, ptr=3 (first priority to requester 0).
REQ-023 Reset asserted mid-grant SHALL drop the grant asynchronously; first grant after deassert follows REQ-012 with ptr=3.

Structure
REQ-024 Shared package arb_pkg SHALL hold N_REQ=4, IDX_W=2, HOLD_W=8, and the state enum (IDLE, GRANT).
REQ-025 One combinational sub-module rr_pick SHALL take (req mask, ptr) and return (found, idx), a rotating 4-to-2 priority encoder; the top level holds FSM, ptr, hold_cnt and output registers.

Verification
REQ-026 Reset then req=4'b1111 held, done pulsed each grant -> grant order 0,1,2,3,0 on consecutive grants, each 1 cycle after done.
REQ-027 req=4'b0100 alone for 20 cycles -> gnt=4'b0100, gnt_idx=2, held all 20 cycles, no preemption.
REQ-028 MAX_HOLD=8, req=4'b0011, no done -> requester 0 granted 8 cycles, then requester 1 8 cycles, alternating.
REQ-029 Owner 2 drops req[2] while req=4'b1001 -> next cycle gnt=4'b1000 (idx 3, search 3,0,1,2).
REQ-030 rst asserted during grant to idx 1 -> outputs zero without waiting for clk; after release with req=4'b0110 -> gnt=4'b0010.
REQ-031 Release with req=0 -> IDLE, gnt_valid=0 next cycle; new req=4'b1000 -> gnt=4'b1000 one cycle later.
